// File: rtl/vga_out_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vga_out_ctrl_pkg
// Shared constants and helpers for the VGA output controller.
//   - Default 640x480@60 timing (H_TOT = 800, V_TOT = 525 at a 25 MHz pixel clock)
//   - Counter and pixel widths
//   - Packed RGB pixel type and the colour-bar index helper
// -----------------------------------------------------------------------------
package vga_out_ctrl_pkg;

    localparam int PIX_W = 10;
    localparam int CNT_W = 10;

    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_TOT  = DEF_H_ACT + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_TOT  = DEF_V_ACT + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Test pattern: eight vertical bars, each 80 pixels wide
    localparam int BAR_W    = 80;
    localparam int NUM_BARS = 8;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    // Bar index = x / 80, built as a compare chain so no divider is inferred
    function automatic logic [2:0] barIndex(input logic [CNT_W-1:0] x);
        logic [2:0] idx;
        idx = '0;
        for (int i = 1; i < NUM_BARS; i++) begin
            if (x >= CNT_W'(i * BAR_W)) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_out_ctrl_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Horizontal/vertical raster counters with active and sync decode.
// Ports:
//   clk, rst        : pixel clock, asynchronous active-high reset
//   h, v            : current raster position
//   hNext, vNext    : position the counters move to on the next edge
//   active          : (h, v) lies inside the visible area
//   hSync, vSync    : (h, v) lies inside the horizontal / vertical sync region
//   activeNext      : (hNext, vNext) lies inside the visible area
// -----------------------------------------------------------------------------
module vga_timing
    import vga_out_ctrl_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic [CNT_W-1:0] hNext,
    output logic [CNT_W-1:0] vNext,
    output logic             active,
    output logic             hSync,
    output logic             vSync,
    output logic             activeNext
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_L    = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_L    = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACT + V_FP + V_SYNC);

    function automatic logic inActive(input logic [CNT_W-1:0] hh,
                                      input logic [CNT_W-1:0] vv);
        return (hh < H_ACT_L) && (vv < V_ACT_L);
    endfunction

    always_comb begin
        hNext = (h == H_MAX) ? '0 : h + CNT_W'(1);
        vNext = v;
        if (h == H_MAX) begin
            vNext = (v == V_MAX) ? '0 : v + CNT_W'(1);
        end
    end

    // Reset parks the raster on the last position so the first edge lands on (0,0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= H_MAX;
            v <= V_MAX;
        end else begin
            h <= hNext;
            v <= vNext;
        end
    end

    assign active     = inActive(h, v);
    assign activeNext = inActive(hNext, vNext);
    assign hSync      = (h >= HS_START) && (h < HS_END);
    assign vSync      = (v >= VS_START) && (v < VS_END);

endmodule

// File: rtl/vga_out_ctrl.sv
// -----------------------------------------------------------------------------
// vga_out_ctrl
// VGA output controller: requests pixels from upstream in raster order and
// drives the DAC with colour, syncs and blanking aligned to the returned data.
// Ports:
//   iCLK, iRST             : 25 MHz pixel clock, asynchronous active-high reset
//   iRed/iGreen/iBlue      : pixel returned by upstream one cycle after oRequest
//   iPattern               : 1 = colour bars instead of upstream pixels (per frame)
//   oRequest, oX, oY       : pixel request and its column/line (0 when idle)
//   oFrameStart            : pulse with the request for pixel (0,0)
//   oVGA_R/G/B             : colour to DAC, forced to 0 during blanking
//   oVGA_HS, oVGA_VS       : active-low syncs
//   oVGA_BLANK_N           : 0 = blank
//   oVGA_SYNC_N            : tied to 0
// -----------------------------------------------------------------------------
module vga_out_ctrl
    import vga_out_ctrl_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [PIX_W-1:0] iRed,
    input  logic [PIX_W-1:0] iGreen,
    input  logic [PIX_W-1:0] iBlue,
    input  logic             iPattern,
    output logic             oRequest,
    output logic [CNT_W-1:0] oX,
    output logic [CNT_W-1:0] oY,
    output logic             oFrameStart,
    output logic [PIX_W-1:0] oVGA_R,
    output logic [PIX_W-1:0] oVGA_G,
    output logic [PIX_W-1:0] oVGA_B,
    output logic             oVGA_HS,
    output logic             oVGA_VS,
    output logic             oVGA_BLANK_N,
    output logic             oVGA_SYNC_N
);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic [CNT_W-1:0] hNext;
    logic [CNT_W-1:0] vNext;
    logic             active;
    logic             hSync;
    logic             vSync;
    logic             activeNext;

    logic             patternEn;
    logic             vld_p1;
    logic             hSyncN_p1;
    logic             vSyncN_p1;
    logic [CNT_W-1:0] x_p1;
    rgb_t             pixIn;
    rgb_t             pixSel;

    vga_timing #(
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) uTiming (
        .clk        (iCLK),
        .rst        (iRST),
        .h          (h),
        .v          (v),
        .hNext      (hNext),
        .vNext      (vNext),
        .active     (active),
        .hSync      (hSync),
        .vSync      (vSync),
        .activeNext (activeNext)
    );

    // Bar index bits select full-scale red / green / blue
    function automatic rgb_t barColour(input logic [CNT_W-1:0] x);
        logic [2:0] idx;
        rgb_t       c;
        idx = barIndex(x);
        c.r = {PIX_W{idx[2]}};
        c.g = {PIX_W{idx[1]}};
        c.b = {PIX_W{idx[0]}};
        return c;
    endfunction

    // Colour is clamped to black outside the visible area
    function automatic rgb_t blankGate(input rgb_t c, input logic visible);
        return visible ? c : '0;
    endfunction

    always_comb begin
        pixIn.r = iRed;
        pixIn.g = iGreen;
        pixIn.b = iBlue;
        pixSel  = patternEn ? barColour(x_p1) : pixIn;
    end

    // Request stage: built from the counters' next state so the registered
    // request matches the raster position held in the same cycle
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oRequest    <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oFrameStart <= 1'b0;
            patternEn   <= 1'b0;
        end else begin
            oRequest    <= activeNext;
            oX          <= activeNext ? hNext : '0;
            oY          <= activeNext ? vNext : '0;
            oFrameStart <= activeNext && (hNext == '0) && (vNext == '0);
            // Sampled once per frame so the source never switches mid-frame
            if ((h == '0) && (v == '0)) patternEn <= iPattern;
        end
    end

    // Stage 1: upstream is fetching the pixel requested last cycle
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            vld_p1    <= 1'b0;
            hSyncN_p1 <= 1'b1;
            vSyncN_p1 <= 1'b1;
        end else begin
            vld_p1    <= active;
            hSyncN_p1 <= ~hSync;
            vSyncN_p1 <= ~vSync;
        end
    end

    always_ff @(posedge iCLK) begin
        x_p1 <= oX;
    end

    // Stage 2: returned pixel and aligned controls go to the DAC
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_BLANK_N <= 1'b0;
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
        end else begin
            oVGA_HS      <= hSyncN_p1;
            oVGA_VS      <= vSyncN_p1;
            oVGA_BLANK_N <= vld_p1;
            {oVGA_R, oVGA_G, oVGA_B} <= blankGate(pixSel, vld_p1);
        end
    end

    assign oVGA_SYNC_N = 1'b0;

endmodule
